// File: rtl/irq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_arbiter_pkg
//  Brief    : Shared state encodings, source ids, default MSI vectors and the
//             vector-selection helper for the interrupt arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package irq_arbiter_pkg;

    // One-hot arbiter states
    typedef enum logic [3:0] {
        IRQ_IDLE  = 4'b0001,
        IRQ_ISSUE = 4'b0010,
        IRQ_ACK   = 4'b0100,
        IRQ_GAP   = 4'b1000
    } irq_state_t;

    // Source ids (also the encoding of last_grant)
    localparam logic SRC_RX = 1'b0;
    localparam logic SRC_TX = 1'b1;

    // Default vectors so both generators and the arbiter agree
    localparam int unsigned DEF_RX_VECTOR = 0;
    localparam int unsigned DEF_TX_VECTOR = 1;

    // Host may grant at most 2^5 = 32 vectors; larger codes are reserved
    localparam logic [2:0] MM_MAX = 3'd5;

    // MSI data for a vector: the vector itself if MSI is on and the vector
    // fits inside the host-granted range, otherwise vector 0.
    function automatic logic [7:0] irq_vec_sel(
        input logic [4:0] vec,
        input logic       msien,
        input logic [2:0] mmen
    );
        logic [2:0] mm;
        logic [5:0] lim;
        mm  = (mmen > MM_MAX) ? MM_MAX : mmen;
        lim = 6'd1 << mm;
        if (msien && ({1'b0, vec} < lim)) begin
            return {3'b000, vec};
        end
        return 8'h00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : irq_arbiter
//  Brief    : Merges the rx and tx cfg_interrupt handshakes onto the single
//             PCIe endpoint interrupt port. Round-robin arbitration, per-source
//             MSI vector, enforced idle gap and stuck-handshake timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int unsigned RX_VECTOR = DEF_RX_VECTOR,
    parameter int unsigned TX_VECTOR = DEF_TX_VECTOR,
    parameter int unsigned MIN_GAP   = 4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_cfg_interrupt_n,
    output logic        rx_cfg_interrupt_rdy_n,
    input  logic        tx_cfg_interrupt_n,
    output logic        tx_cfg_interrupt_rdy_n,
    output logic        cfg_interrupt_n,
    input  logic        cfg_interrupt_rdy_n,
    output logic [7:0]  cfg_interrupt_di,
    input  logic        cfg_interrupt_msienable,
    input  logic [2:0]  cfg_interrupt_mmenable,
    output logic        irq_timeout_err,
    output logic [31:0] rx_irq_count,
    output logic [31:0] tx_irq_count
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;

    localparam logic [4:0]    c_RX_VEC   = 5'(RX_VECTOR);
    localparam logic [4:0]    c_TX_VEC   = 5'(TX_VECTOR);
    localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [7:0]    c_GAP_LAST = 8'(MIN_GAP - 1);

    irq_state_t    r_state,     w_state;
    logic          r_cfg_n,     w_cfg_n;
    logic [7:0]    r_di,        w_di;
    logic          r_rx_rdy_n,  w_rx_rdy_n;
    logic          r_tx_rdy_n,  w_tx_rdy_n;
    logic          r_err,       w_err;
    logic [31:0]   r_rx_cnt,    w_rx_cnt;
    logic [31:0]   r_tx_cnt,    w_tx_cnt;
    logic          r_last,      w_last;
    logic          r_cur,       w_cur;
    logic [TW-1:0] r_timer,     w_timer;
    logic [7:0]    r_gap,       w_gap;

    logic          w_rx_req;
    logic          w_tx_req;
    logic          w_sel;
    logic [4:0]    w_vec;
    logic [7:0]    w_di_sel;

    assign w_rx_req = ~rx_cfg_interrupt_n;
    assign w_tx_req = ~tx_cfg_interrupt_n;
    // Contention goes to the source that was not served last; otherwise the
    // lone requester (tx if tx alone, rx if rx alone).
    assign w_sel    = (w_rx_req & w_tx_req) ? ~r_last : w_tx_req;
    assign w_vec    = (w_sel == SRC_RX) ? c_RX_VEC : c_TX_VEC;
    assign w_di_sel = irq_vec_sel(w_vec, cfg_interrupt_msienable, cfg_interrupt_mmenable);

    // Next-state and next-output computation; every output is registered
    always_comb begin
        w_state    = r_state;
        w_cfg_n    = r_cfg_n;
        w_di       = r_di;
        w_rx_rdy_n = 1'b1;
        w_tx_rdy_n = 1'b1;
        w_err      = r_err;
        w_rx_cnt   = r_rx_cnt;
        w_tx_cnt   = r_tx_cnt;
        w_last     = r_last;
        w_cur      = r_cur;
        w_timer    = r_timer;
        w_gap      = r_gap;
        case (r_state)
            IRQ_IDLE: begin
                if (w_rx_req || w_tx_req) begin
                    w_cur   = w_sel;
                    w_last  = w_sel;
                    w_di    = w_di_sel;
                    w_cfg_n = 1'b0;
                    w_timer = '0;
                    w_state = IRQ_ISSUE;
                end
            end
            IRQ_ISSUE: begin
                if (!cfg_interrupt_rdy_n) begin
                    w_cfg_n = 1'b1;
                    w_state = IRQ_ACK;
                end else if (r_timer == c_TO_LAST) begin
                    // Core never accepted: abort, flag it, still ack requester
                    w_cfg_n = 1'b1;
                    w_err   = 1'b1;
                    w_state = IRQ_ACK;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            IRQ_ACK: begin
                if (r_cur == SRC_RX) begin
                    w_rx_rdy_n = 1'b0;
                    w_rx_cnt   = r_rx_cnt + 32'd1;
                end else begin
                    w_tx_rdy_n = 1'b0;
                    w_tx_cnt   = r_tx_cnt + 32'd1;
                end
                w_gap   = 8'd0;
                w_state = IRQ_GAP;
            end
            IRQ_GAP: begin
                // Requests ignored here so the acked requester has released
                if (r_gap == c_GAP_LAST) begin
                    w_state = IRQ_IDLE;
                end else begin
                    w_gap = r_gap + 8'd1;
                end
            end
            default: begin
                w_state = IRQ_IDLE;
                w_cfg_n = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IRQ_IDLE;
            r_cfg_n    <= 1'b1;
            r_di       <= 8'h00;
            r_rx_rdy_n <= 1'b1;
            r_tx_rdy_n <= 1'b1;
            r_err      <= 1'b0;
            r_rx_cnt   <= 32'd0;
            r_tx_cnt   <= 32'd0;
            r_last     <= SRC_TX;
            r_cur      <= SRC_RX;
            r_timer    <= '0;
            r_gap      <= 8'd0;
        end else begin
            r_state    <= w_state;
            r_cfg_n    <= w_cfg_n;
            r_di       <= w_di;
            r_rx_rdy_n <= w_rx_rdy_n;
            r_tx_rdy_n <= w_tx_rdy_n;
            r_err      <= w_err;
            r_rx_cnt   <= w_rx_cnt;
            r_tx_cnt   <= w_tx_cnt;
            r_last     <= w_last;
            r_cur      <= w_cur;
            r_timer    <= w_timer;
            r_gap      <= w_gap;
        end
    end

    assign cfg_interrupt_n        = r_cfg_n;
    assign cfg_interrupt_di       = r_di;
    assign rx_cfg_interrupt_rdy_n = r_rx_rdy_n;
    assign tx_cfg_interrupt_rdy_n = r_tx_rdy_n;
    assign irq_timeout_err        = r_err;
    assign rx_irq_count           = r_rx_cnt;
    assign tx_irq_count           = r_tx_cnt;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_arbiter
//  Brief    : Self-checking bench for irq_arbiter: directed scenarios plus
//             randomized traffic against a transaction-timeline model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

    localparam int RXV  = 6;
    localparam int TXV  = 1;
    localparam int GAP  = 4;
    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_n, tx_n, core_rdy_n, msien;
    logic [2:0]  mmen;
    logic        rx_rdy_n, tx_rdy_n, cfg_n, err;
    logic [7:0]  di;
    logic [31:0] rx_cnt, tx_cnt;

    irq_arbiter #(.RX_VECTOR(RXV), .TX_VECTOR(TXV), .MIN_GAP(GAP), .TIMEOUT(TOUT)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .rx_cfg_interrupt_n      (rx_n),
        .rx_cfg_interrupt_rdy_n  (rx_rdy_n),
        .tx_cfg_interrupt_n      (tx_n),
        .tx_cfg_interrupt_rdy_n  (tx_rdy_n),
        .cfg_interrupt_n         (cfg_n),
        .cfg_interrupt_rdy_n     (core_rdy_n),
        .cfg_interrupt_di        (di),
        .cfg_interrupt_msienable (msien),
        .cfg_interrupt_mmenable  (mmen),
        .irq_timeout_err         (err),
        .rx_irq_count            (rx_cnt),
        .tx_irq_count            (tx_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;

    // Inputs the DUT saw at the most recent edge
    bit p_reset, p_rx, p_tx, p_core, p_msien;
    int p_mmen;

    // Timeline model
    bit          m_busy, m_last, m_src, m_err;
    int          m_t0, m_ack_at, m_ready_at;
    int          m_di;
    logic [31:0] m_cnt_rx, m_cnt_tx;

    // Agents
    int rx_todo = 0, tx_todo = 0, rx_made = 0, tx_made = 0;
    bit rx_eager = 1, tx_eager = 1, core_rand = 0;
    int core_delay = 3, core_cnt = 0;

    // Observations
    int obs_src[$];
    int obs_di[$];
    int obs_len[$];
    int obs_low = 0;
    bit obs_prev_cfg = 1;

    function automatic int exp_vec(int vec, bit en, int mm);
        int m;
        m = (mm > 5) ? 5 : mm;
        return (en && vec < (1 << m)) ? vec : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_step();
        bit e_rx_rdy, e_tx_rdy;
        e_rx_rdy = 1;
        e_tx_rdy = 1;
        if (p_reset) begin
            m_busy = 0; m_last = 1; m_err = 0; m_di = 0;
            m_cnt_rx = 0; m_cnt_tx = 0; m_ack_at = -1; m_ready_at = 0;
        end else begin
            if (m_busy) begin
                if (!p_core || (t - m_t0 == TOUT)) begin
                    if (p_core) m_err = 1;
                    m_busy     = 0;
                    m_ack_at   = t + 1;
                    m_ready_at = t + 2 + GAP;
                end
            end else if (t >= m_ready_at && (!p_rx || !p_tx)) begin
                if (!p_rx && !p_tx) m_src = !m_last;
                else                m_src = !p_rx ? 1'b0 : 1'b1;
                m_last = m_src;
                m_busy = 1;
                m_t0   = t;
                m_di   = exp_vec(m_src ? TXV : RXV, p_msien, p_mmen);
            end
            if (t == m_ack_at) begin
                if (m_src == 0) begin e_rx_rdy = 0; m_cnt_rx++; end
                else            begin e_tx_rdy = 0; m_cnt_tx++; end
            end
        end
        chk("cfg_n",    cfg_n,    !m_busy);
        chk("di",       di,       m_di);
        chk("rx_rdy_n", rx_rdy_n, e_rx_rdy);
        chk("tx_rdy_n", tx_rdy_n, e_tx_rdy);
        chk("err",      err,      m_err);
        chk("rx_count", rx_cnt,   m_cnt_rx);
        chk("tx_count", tx_cnt,   m_cnt_tx);
    endtask

    task automatic observe();
        if (cfg_n === 1'b0 && obs_prev_cfg) obs_di.push_back(int'(di));
        if (cfg_n === 1'b0) obs_low++;
        else if (obs_low > 0) begin obs_len.push_back(obs_low); obs_low = 0; end
        obs_prev_cfg = (cfg_n !== 1'b0);
        if (rx_rdy_n === 1'b0) obs_src.push_back(0);
        if (tx_rdy_n === 1'b0) obs_src.push_back(1);
    endtask

    task automatic agents();
        if (!rx_n && rx_rdy_n === 1'b0) rx_n = 1;
        else if (rx_n && rx_todo > 0 && (rx_eager || $urandom_range(0, 3) == 0)) begin
            rx_n = 0; rx_todo--; rx_made++;
        end
        if (!tx_n && tx_rdy_n === 1'b0) tx_n = 1;
        else if (tx_n && tx_todo > 0 && (tx_eager || $urandom_range(0, 3) == 0)) begin
            tx_n = 0; tx_todo--; tx_made++;
        end
        if (cfg_n === 1'b0) begin
            core_rdy_n = (core_delay >= 0 && core_cnt == core_delay) ? 1'b0 : 1'b1;
            core_cnt++;
        end else begin
            core_rdy_n = 1;
            core_cnt   = 0;
            if (core_rand) core_delay = $urandom_range(0, 5);
        end
    endtask

    task automatic cyc();
        p_reset = reset; p_rx = rx_n; p_tx = tx_n; p_core = core_rdy_n;
        p_msien = msien; p_mmen = int'(mmen);
        @(posedge clk);
        #1;
        t++;
        model_step();
        observe();
        agents();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic clear_obs();
        obs_src.delete(); obs_di.delete(); obs_len.delete();
    endtask

    task automatic do_reset();
        reset = 1; rx_n = 1; tx_n = 1; rx_todo = 0; tx_todo = 0;
        rx_made = 0; tx_made = 0;
        run(2);
        reset = 0;
    endtask

    initial begin
        reset = 1; rx_n = 1; tx_n = 1; core_rdy_n = 1; msien = 1; mmen = 3'd1;
        run(3);
        chk("reset_cfg_n", cfg_n, 1'b1);
        chk("reset_di",    di,    8'h00);
        chk("reset_rdy",   {rx_rdy_n, tx_rdy_n}, 2'b11);
        chk("reset_err",   err,   1'b0);
        chk("reset_cnts",  rx_cnt | tx_cnt, 32'd0);
        reset = 0;

        // Single rx interrupt, core accepts three cycles after the request
        clear_obs(); core_delay = 3; rx_todo = 1;
        run(30);
        chk("t1_n_acks", obs_src.size(), 1);
        if (obs_src.size() == 1) chk("t1_src", obs_src[0], 0);
        chk("t1_n_issue", obs_di.size(), 1);
        if (obs_di.size() == 1) chk("t1_di", obs_di[0], 0);
        if (obs_len.size() == 1) chk("t1_len", obs_len[0], 4);
        chk("t1_rx_count", rx_cnt, 1);

        // Simultaneous requests straight after reset: rx first, then tx
        do_reset(); clear_obs(); rx_todo = 1; tx_todo = 1;
        run(40);
        chk("t2_n_acks", obs_src.size(), 2);
        if (obs_src.size() == 2) begin
            chk("t2_first",  obs_src[0], 0);
            chk("t2_second", obs_src[1], 1);
        end
        if (obs_di.size() == 2) chk("t2_tx_di", obs_di[1], TXV);

        // Vector selection under host MSI configuration
        clear_obs(); msien = 0; tx_todo = 1; run(30);
        if (obs_di.size() == 1) chk("t3_msi_off", obs_di[0], 0); else chk("t3_msi_off_n", obs_di.size(), 1);
        clear_obs(); msien = 1; mmen = 3'd0; tx_todo = 1; run(30);
        if (obs_di.size() == 1) chk("t3_mm0", obs_di[0], 0); else chk("t3_mm0_n", obs_di.size(), 1);
        clear_obs(); mmen = 3'd7; rx_todo = 1; run(30);
        if (obs_di.size() == 1) chk("t3_mm7_rx", obs_di[0], RXV); else chk("t3_mm7_n", obs_di.size(), 1);
        clear_obs(); mmen = 3'd2; rx_todo = 1; run(30);
        if (obs_di.size() == 1) chk("t3_mm2_rx", obs_di[0], 0); else chk("t3_mm2_n", obs_di.size(), 1);

        // Core never answers: abort after TIMEOUT cycles, requester still acked
        clear_obs(); mmen = 3'd1; core_delay = -1; rx_todo = 1;
        run(40);
        chk("t4_n_issue", obs_len.size(), 1);
        if (obs_len.size() == 1) chk("t4_len", obs_len[0], TOUT);
        chk("t4_err", err, 1'b1);
        chk("t4_acked", obs_src.size(), 1);
        core_delay = 2; tx_todo = 1; run(30);
        chk("t4_err_sticky", err, 1'b1);

        // Reset while the core is being asked
        core_delay = -1; rx_todo = 1;
        for (int i = 0; i < 20 && cfg_n !== 1'b0; i++) cyc();
        chk("t5_in_issue", cfg_n, 1'b0);
        run(3);
        reset = 1; rx_n = 1; rx_todo = 0;
        cyc();
        chk("t5_cfg_n", cfg_n, 1'b1);
        chk("t5_counts", rx_cnt | tx_cnt, 32'd0);
        chk("t5_err", err, 1'b0);
        reset = 0; core_delay = 2; tx_todo = 1;
        cyc(); cyc();
        chk("t5_idle_grant", cfg_n, 1'b0);
        run(30);

        // Both keep re-requesting: grants must alternate
        do_reset(); clear_obs(); rx_todo = 3; tx_todo = 2;
        run(80);
        chk("t6_n_acks", obs_src.size(), 5);
        if (obs_src.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("t6_order%0d", i), obs_src[i], i % 2);
        chk("t6_rx_count", rx_cnt, 3);
        chk("t6_tx_count", tx_cnt, 2);

        // Randomized traffic, host configuration and core latency
        do_reset(); rx_eager = 0; tx_eager = 0; core_rand = 1;
        for (int r = 0; r < 20; r++) begin
            msien   = 1'($urandom_range(0, 3) != 0);
            mmen    = 3'($urandom_range(0, 7));
            rx_todo += $urandom_range(0, 3);
            tx_todo += $urandom_range(0, 3);
            run(60);
        end
        rx_todo = 0; tx_todo = 0;
        run(100);
        chk("rand_rx_total", rx_cnt, rx_made);
        chk("rand_tx_total", tx_cnt, tx_made);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
